// File: rtl/l2_interleave_router.sv
// l2_interleave_router: routes upstream L2 requests to one of NumChannels
// channels (interleaved or contiguous address map) and returns responses in
// request order using a small FIFO of channel indices.
module l2_interleave_router #(
  parameter int unsigned NumChannels     = 4,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned DataWidth       = 256,
  parameter int unsigned InterleaveBytes = 16384,
  parameter int unsigned ChanSizeBytes   = 32'h1000_0000,
  parameter int unsigned MaxOutstanding  = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             cfg_interleave_i,
  output logic                             mode_o,
  output logic                             busy_o,
  output logic [$clog2(MaxOutstanding):0]  outstanding_o,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [AddrWidth-1:0]             req_addr_i,
  input  logic                             req_write_i,
  input  logic [DataWidth-1:0]             req_wdata_i,
  input  logic [DataWidth/8-1:0]           req_strb_i,
  output logic [NumChannels-1:0]           ch_req_valid_o,
  input  logic [NumChannels-1:0]           ch_req_ready_i,
  output logic [NumChannels*AddrWidth-1:0] ch_req_addr_o,
  output logic                             ch_req_write_o,
  output logic [DataWidth-1:0]             ch_req_wdata_o,
  output logic [DataWidth/8-1:0]           ch_req_strb_o,
  input  logic [NumChannels-1:0]           ch_rsp_valid_i,
  output logic [NumChannels-1:0]           ch_rsp_ready_o,
  input  logic [NumChannels*DataWidth-1:0] ch_rsp_data_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [DataWidth-1:0]             rsp_data_o
);

  localparam int C  = $clog2(InterleaveBytes);
  localparam int S  = $clog2(NumChannels);
  localparam int Z  = $clog2(ChanSizeBytes);
  localparam int PW = $clog2(MaxOutstanding);
  localparam int CW = PW + 1;

  logic [S-1:0]         fifo_q [MaxOutstanding];
  logic [S-1:0]         fifo_d [MaxOutstanding];
  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 mode_q, mode_d;
  logic                 busy_q, busy_d;

  logic [S-1:0]         ch_idx_s;
  logic [S-1:0]         head_s;
  logic [AddrWidth-1:0] ilv_addr_s;
  logic [AddrWidth-1:0] route_addr_s;
  logic                 full_s, empty_s, accept_s, retire_s;

  // Interleaved address remap: the channel-select bits move up to the
  // channel-span position so each channel sees a dense address range.
  if (C < Z) begin : g_remap
    localparam logic [AddrWidth-1:0] TopMask = {AddrWidth{1'b1}} << (Z + S);
    localparam logic [AddrWidth-1:0] MidMask = {AddrWidth{1'b1}} >> (AddrWidth - (Z - C));
    localparam logic [AddrWidth-1:0] LowMask = {AddrWidth{1'b1}} >> (AddrWidth - C);
    assign ilv_addr_s = (req_addr_i & TopMask)
                      | (AddrWidth'(req_addr_i[C+S-1:C]) << Z)
                      | (((req_addr_i >> (C + S)) & MidMask) << C)
                      | (req_addr_i & LowMask);
  end else begin : g_passthru
    assign ilv_addr_s = req_addr_i;
  end

  assign full_s  = (count_q == CW'(MaxOutstanding));
  assign empty_s = (count_q == {CW{1'b0}});
  assign head_s  = fifo_q[rptr_q];

  // Channel selection and address using the applied mode (never the raw config).
  always_comb begin
    ch_idx_s     = req_addr_i[Z+S-1:Z];
    route_addr_s = req_addr_i;
    if (mode_q) begin
      ch_idx_s     = req_addr_i[C+S-1:C];
      route_addr_s = ilv_addr_s;
    end else begin
      ch_idx_s     = req_addr_i[Z+S-1:Z];
      route_addr_s = req_addr_i;
    end
  end

  // Request/response routing; valid never depends on ready.
  always_comb begin
    ch_req_valid_o = {NumChannels{1'b0}};
    ch_rsp_ready_o = {NumChannels{1'b0}};
    if (req_valid_i && !full_s) begin
      ch_req_valid_o[ch_idx_s] = 1'b1;
    end else begin
      ch_req_valid_o = {NumChannels{1'b0}};
    end
    if (rsp_ready_i && !empty_s) begin
      ch_rsp_ready_o[head_s] = 1'b1;
    end else begin
      ch_rsp_ready_o = {NumChannels{1'b0}};
    end
  end

  assign req_ready_o    = ch_req_ready_i[ch_idx_s] && !full_s;
  assign rsp_valid_o    = !empty_s && ch_rsp_valid_i[head_s];
  assign rsp_data_o     = ch_rsp_data_i[int'(head_s)*DataWidth +: DataWidth];
  assign ch_req_addr_o  = {NumChannels{route_addr_s}};
  assign ch_req_write_o = req_write_i;
  assign ch_req_wdata_o = req_wdata_i;
  assign ch_req_strb_o  = req_strb_i;
  assign accept_s       = req_valid_i && req_ready_o;
  assign retire_s       = rsp_valid_o && rsp_ready_i;
  assign mode_o         = mode_q;
  assign busy_o         = busy_q;
  assign outstanding_o  = count_q;

  // Next-state for the order FIFO, occupancy count and mode register.
  always_comb begin
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    count_d = count_q;
    if (accept_s) begin
      fifo_d[wptr_q] = ch_idx_s;
      wptr_d = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (retire_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    if (accept_s && !retire_s) begin
      count_d = count_q + CW'(1);
    end else if (retire_s && !accept_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
    // Mode may only change when nothing is in flight or being presented.
    if (empty_s && !req_valid_i) begin
      mode_d = cfg_interleave_i;
    end else begin
      mode_d = mode_q;
    end
    busy_d = (count_d != {CW{1'b0}});
  end

  // State registers; reset discards all order state at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        fifo_q[i] <= {S{1'b0}};
      end
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      mode_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      fifo_q  <= fifo_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_l2_interleave_router.sv
// Self-checking bench for l2_interleave_router: a queue-based reference model
// checked every negedge, plus literal expectations for the key scenarios.
module tb_l2_interleave_router;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_interleave;
  logic              mode, busy;
  logic [3:0]        outstanding;
  logic              req_valid, req_ready;
  logic [AW-1:0]     req_addr;
  logic              req_write;
  logic [DW-1:0]     req_wdata;
  logic [DW/8-1:0]   req_strb;
  logic [NC-1:0]     ch_req_valid, ch_req_ready;
  logic [NC*AW-1:0]  ch_req_addr;
  logic              ch_req_write;
  logic [DW-1:0]     ch_req_wdata;
  logic [DW/8-1:0]   ch_req_strb;
  logic [NC-1:0]     ch_rsp_valid, ch_rsp_ready;
  logic [NC*DW-1:0]  ch_rsp_data;
  logic              rsp_valid, rsp_ready;
  logic [DW-1:0]     rsp_data;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  int m_q[$];
  logic m_mode;

  l2_interleave_router dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_interleave_i(cfg_interleave),
    .mode_o(mode), .busy_o(busy), .outstanding_o(outstanding),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .ch_req_valid_o(ch_req_valid), .ch_req_ready_i(ch_req_ready),
    .ch_req_addr_o(ch_req_addr), .ch_req_write_o(ch_req_write),
    .ch_req_wdata_o(ch_req_wdata), .ch_req_strb_o(ch_req_strb),
    .ch_rsp_valid_i(ch_rsp_valid), .ch_rsp_ready_o(ch_rsp_ready),
    .ch_rsp_data_i(ch_rsp_data), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_chan(input logic md, input logic [31:0] a);
    longint unsigned ua = a;
    if (md) return int'((ua / 64'd16384) % 64'd4);
    else    return int'((ua / 64'd268435456) % 64'd4);
  endfunction

  function automatic logic [31:0] model_addr(input logic md, input logic [31:0] a);
    longint unsigned ua = a;
    longint unsigned r;
    if (!md) return a;
    r = (ua / 64'd1073741824) * 64'd1073741824
      + ((ua / 64'd16384) % 64'd4) * 64'd268435456
      + ((ua / 64'd65536) % 64'd16384) * 64'd16384
      + (ua % 64'd16384);
    return r[31:0];
  endfunction

  function automatic logic [DW-1:0] chan_data(input int k);
    logic [31:0] w = 32'hD000_0000 + k;
    return {8{w}};
  endfunction

  // Per-cycle compare against the model, then advance the model to the next edge.
  always @(negedge clk) begin
    int ch, head;
    bit full, empty, exp_rspv, acc, ret;
    logic [NC-1:0] exp_chv, exp_chrr;
    logic exp_rdy;
    if (!rst_n) begin
      m_q.delete();
      m_mode = 1'b1;
    end
    full  = (m_q.size() == 8);
    empty = (m_q.size() == 0);
    ch    = model_chan(m_mode, req_addr);
    head  = empty ? 0 : m_q[0];
    exp_chv  = (req_valid && !full) ? NC'(1 << ch) : '0;
    exp_rdy  = ch_req_ready[ch] && !full;
    exp_rspv = !empty && ch_rsp_valid[head];
    exp_chrr = (rsp_ready && !empty) ? NC'(1 << head) : '0;
    check("outstanding", 256'(outstanding), 256'(m_q.size()));
    check("busy", 256'(busy), 256'(m_q.size() != 0));
    check("mode", 256'(mode), 256'(m_mode));
    check("ch_req_valid", 256'(ch_req_valid), 256'(exp_chv));
    check("req_ready", 256'(req_ready), 256'(exp_rdy));
    check("rsp_valid", 256'(rsp_valid), 256'(exp_rspv));
    check("ch_rsp_ready", 256'(ch_rsp_ready), 256'(exp_chrr));
    if (req_valid) check("ch_req_addr", 256'(ch_req_addr[ch*AW +: AW]), 256'(model_addr(m_mode, req_addr)));
    if (exp_rspv) check("rsp_data", rsp_data, chan_data(head));
    if (rst_n) begin
      acc = req_valid && exp_rdy;
      ret = exp_rspv && rsp_ready;
      if (empty && !req_valid) m_mode = cfg_interleave;
      if (ret) void'(m_q.pop_front());
      if (acc) m_q.push_back(ch);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cfg_interleave = 1'b1; req_valid = 1'b0; req_addr = 32'h0;
    req_write = 1'b0; req_wdata = '0; req_strb = '0; ch_req_ready = 4'b1111;
    ch_rsp_valid = 4'b0000; rsp_ready = 1'b0;
    for (int k = 0; k < NC; k++) ch_rsp_data[k*DW +: DW] = chan_data(k);
    m_mode = 1'b1;
    step(); step();
    check("rst_outstanding", 256'(outstanding), 256'(0));
    check("rst_mode", 256'(mode), 256'(1));
    check("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    rst_n = 1'b1;
    step();

    // interleaved routing of 0x8000_4000
    req_valid = 1'b1; req_addr = 32'h8000_4000; req_write = 1'b1;
    req_wdata = {8{32'hA5A5_0001}}; req_strb = '1;
    #1;
    check("ilv_valid", 256'(ch_req_valid), 256'(4'b0010));
    check("ilv_addr", 256'(ch_req_addr[1*AW +: AW]), 256'(32'h9000_0000));
    check("ilv_wdata", ch_req_wdata, {8{32'hA5A5_0001}});
    step();
    req_valid = 1'b0; req_write = 1'b0;
    check("ilv_outstanding", 256'(outstanding), 256'(1));
    ch_rsp_valid = 4'b0010; rsp_ready = 1'b1;
    step();
    ch_rsp_valid = 4'b0000; rsp_ready = 1'b0;

    // contiguous mode
    cfg_interleave = 1'b0;
    step();
    check("cont_mode", 256'(mode), 256'(0));
    req_valid = 1'b1; req_addr = 32'h9000_0000;
    #1;
    check("cont_valid", 256'(ch_req_valid), 256'(4'b0010));
    check("cont_addr", 256'(ch_req_addr[1*AW +: AW]), 256'(32'h9000_0000));
    step();
    req_valid = 1'b0; ch_rsp_valid = 4'b0010; rsp_ready = 1'b1;
    step();
    ch_rsp_valid = 4'b0000; rsp_ready = 1'b0; cfg_interleave = 1'b1;
    step();

    // ordering: ch 2 then ch 0, ch 0 answers first
    req_valid = 1'b1; req_addr = 32'h0000_8000; step();
    req_addr = 32'h0000_0000; step();
    req_valid = 1'b0; ch_rsp_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    check("ord_hold_valid", 256'(rsp_valid), 256'(0));
    check("ord_hold_ready0", 256'(ch_rsp_ready[0]), 256'(0));
    step(); step();
    check("ord_hold_cnt", 256'(outstanding), 256'(2));
    ch_rsp_valid = 4'b0101;
    #1;
    check("ord_first_data", rsp_data, chan_data(2));
    step();
    ch_rsp_valid = 4'b0001;
    #1;
    check("ord_second_data", rsp_data, chan_data(0));
    step();
    ch_rsp_valid = 4'b0000; rsp_ready = 1'b0;

    // fill to capacity
    req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_addr = 32'(i) * 32'h4000;
      step();
    end
    check("full_cnt", 256'(outstanding), 256'(8));
    check("full_ready", 256'(req_ready), 256'(0));
    check("full_chv", 256'(ch_req_valid), 256'(0));
    ch_rsp_valid = 4'b1111; rsp_ready = 1'b1;
    step();
    ch_rsp_valid = 4'b0000; rsp_ready = 1'b0;
    check("full_retire_cnt", 256'(outstanding), 256'(7));
    check("full_retire_ready", 256'(req_ready), 256'(1));
    step();
    // simultaneous accept/retire across pointer wrap
    ch_rsp_valid = 4'b1111; rsp_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      req_addr = 32'(i * 7 + 3) * 32'h4000 + 32'(i);
      step();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("drain_cnt", 256'(outstanding), 256'(0));
    ch_rsp_valid = 4'b0000; rsp_ready = 1'b0;

    // mode held while outstanding
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'(i) * 32'h4000;
      step();
    end
    req_valid = 1'b0; cfg_interleave = 1'b0;
    step(); step();
    check("mode_hold_busy", 256'(mode), 256'(1));
    ch_rsp_valid = 4'b1111; rsp_ready = 1'b1;
    step(); step(); step();
    check("mode_hold_last", 256'(mode), 256'(1));
    ch_rsp_valid = 4'b0000; rsp_ready = 1'b0;
    step();
    check("mode_update", 256'(mode), 256'(0));
    cfg_interleave = 1'b1;
    step();

    // asynchronous reset with five in flight
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_addr = 32'(i) * 32'h4000;
      step();
    end
    req_valid = 1'b0; ch_rsp_valid = 4'b1111;
    #1;
    check("pre_rst_cnt", 256'(outstanding), 256'(5));
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", 256'(outstanding), 256'(0));
    check("async_rst_rspv", 256'(rsp_valid), 256'(0));
    step();
    rst_n = 1'b1; rsp_ready = 1'b1;
    step(); step();
    check("stale_rspv", 256'(rsp_valid), 256'(0));
    ch_rsp_valid = 4'b0000; rsp_ready = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
